// File: rtl/click_multi_pkg.sv
// click_pkg: shared FSM state encoding and synchroniser depth for the
// click_multi button bank and its per-channel slices.
package click_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } chanState_e;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/click_multi_if.sv
// click_multi_if: bundles the raw button bank and all per-channel event
// outputs. The front-panel side (master) drives buttons; the debouncer
// (slave) drives levels, pulses and LEDs.
interface click_multi_if #(
  parameter int N_CH = 4
);

  logic [N_CH-1:0] button;
  logic [N_CH-1:0] level_o;
  logic [N_CH-1:0] press_o;
  logic [N_CH-1:0] release_o;
  logic [N_CH-1:0] long_o;
  logic [N_CH-1:0] dbl_o;
  logic [N_CH-1:0] led;

  modport master (
    output button,
    input  level_o,
    input  press_o,
    input  release_o,
    input  long_o,
    input  dbl_o,
    input  led
  );

  modport slave (
    input  button,
    output level_o,
    output press_o,
    output release_o,
    output long_o,
    output dbl_o,
    output led
  );

endinterface

// File: rtl/click_multi_chan.sv
// click_chan: one button channel - synchroniser, debounce counter,
// IDLE/PRESSED/HELD classifier and, when CLICK_MULTI_DBLCLK_EN is defined,
// the double-click window. Without the macro dbl is tied to 0 and no window
// logic exists.
module click_chan
  import click_pkg::*;
#(
  parameter int DEB_CNT  = 250000,
  parameter int LONG_CNT = 25000000,
  parameter int DBL_WIN  = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_button,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_dbl,
  output logic o_led
);

  localparam int DEB_W  = $clog2(DEB_CNT + 1);
  localparam int HOLD_W = $clog2(LONG_CNT + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CNT);

  // Elaboration guard: a mis-parameterised bank should not build silently.
  if (DEB_CNT < 2 || LONG_CNT <= DEB_CNT || DBL_WIN < 1) begin : g_badParams
    $error("click_chan: DEB_CNT>=2, LONG_CNT>DEB_CNT and DBL_WIN>=1 required");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic [DEB_W-1:0]       r_debCnt;
  logic                   r_level;
  logic                   w_mismatch;
  logic                   w_flip;
  logic                   w_pressEv;
  logic                   w_relEv;
  logic [HOLD_W-1:0]      r_holdCnt;
  chanState_e             r_state;
  chanState_e             w_nextState;
  logic                   w_longHit;
  logic                   r_press;
  logic                   r_release;
  logic                   r_long;
  logic                   r_led;

  // Shift the raw asynchronous button through the metastability flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_button};
    end
  end

  assign w_sync     = r_sync[SYNC_STAGES-1];
  assign w_mismatch = (w_sync != r_level);
  assign w_flip     = w_mismatch && (r_debCnt == DEB_LAST);
  assign w_pressEv  = w_flip && w_sync;
  assign w_relEv    = w_flip && !w_sync;

  // Accept a new level only after DEB_CNT consecutive mismatching samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level  <= 1'b0;
      r_debCnt <= '0;
    end else if (w_flip) begin
      r_level  <= ~r_level;
      r_debCnt <= '0;
    end else if (w_mismatch) begin
      r_debCnt <= r_debCnt + 1'b1;
    end else begin
      r_debCnt <= '0;
    end
  end

  // Classifier state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Classifier transitions; a release always beats the long threshold.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_pressEv) w_nextState = PRESSED;
      end
      PRESSED: begin
        if (w_relEv) w_nextState = IDLE;
        else if (r_holdCnt == HOLD_LAST) w_nextState = HELD;
      end
      HELD: begin
        if (w_relEv) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Long-press detection only from PRESSED, suppressed by a same-cycle release.
  always_comb begin
    w_longHit = 1'b0;
    if ((r_state == PRESSED) && !w_relEv && (r_holdCnt == HOLD_LAST)) begin
      w_longHit = 1'b1;
    end
  end

  // Press-duration counter: restarts at each press, saturates instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_holdCnt <= '0;
    end else if (w_pressEv) begin
      r_holdCnt <= '0;
    end else if ((r_state == PRESSED) && (r_holdCnt != HOLD_MAX)) begin
      r_holdCnt <= r_holdCnt + 1'b1;
    end
  end

  // Event pulses line up with the first cycle of the new debounced level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_led     <= 1'b0;
    end else begin
      r_press   <= w_pressEv;
      r_release <= w_relEv;
      r_long    <= w_longHit;
      if (w_pressEv) r_led <= ~r_led;
    end
  end

`ifdef CLICK_MULTI_DBLCLK_EN
  localparam int WIN_W = $clog2(DBL_WIN + 1);
  localparam logic [WIN_W-1:0] WIN_MAX = WIN_W'(DBL_WIN);

  logic [WIN_W-1:0] r_winCnt;
  logic             r_armed;
  logic             r_wasDbl;
  logic             r_dbl;
  logic             w_shortRel;
  logic             w_dblHit;

  assign w_shortRel = w_relEv && (r_state == PRESSED);
  assign w_dblHit   = w_pressEv && r_armed && (r_winCnt < WIN_MAX);

  // Double-click window: armed by a short release that was not itself the
  // second click, so the click after a double-click starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_winCnt <= '0;
      r_armed  <= 1'b0;
      r_wasDbl <= 1'b0;
      r_dbl    <= 1'b0;
    end else begin
      r_dbl <= w_dblHit;
      if (w_pressEv) begin
        r_armed  <= 1'b0;
        r_wasDbl <= w_dblHit;
      end else if (w_relEv) begin
        r_armed  <= w_shortRel && !r_wasDbl;
        r_wasDbl <= 1'b0;
        r_winCnt <= '0;
      end else if (r_armed && (r_winCnt != WIN_MAX)) begin
        r_winCnt <= r_winCnt + 1'b1;
      end
    end
  end

  assign o_dbl = r_dbl;
`else
  assign o_dbl = 1'b0;
`endif

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_long    = r_long;
  assign o_led     = r_led;

endmodule

// File: rtl/click_multi.sv
// click_multi: debounces and classifies a bank of N_CH push-buttons
// (press, release, long-press, toggle LED per channel). Defining
// CLICK_MULTI_DBLCLK_EN adds per-channel double-click detection.
module click_multi
  import click_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int DEB_CNT  = 250000,
  parameter int LONG_CNT = 25000000,
  parameter int DBL_WIN  = 10000000
) (
  input  logic        clk,
  input  logic        rst,
  click_multi_if.slave bus
);

  logic [N_CH-1:0] w_level;
  logic [N_CH-1:0] w_press;
  logic [N_CH-1:0] w_release;
  logic [N_CH-1:0] w_long;
  logic [N_CH-1:0] w_dbl;
  logic [N_CH-1:0] w_led;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    click_chan #(
      .DEB_CNT  (DEB_CNT),
      .LONG_CNT (LONG_CNT),
      .DBL_WIN  (DBL_WIN)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .i_button  (bus.button[i]),
      .o_level   (w_level[i]),
      .o_press   (w_press[i]),
      .o_release (w_release[i]),
      .o_long    (w_long[i]),
      .o_dbl     (w_dbl[i]),
      .o_led     (w_led[i])
    );
  end

  assign bus.level_o   = w_level;
  assign bus.press_o   = w_press;
  assign bus.release_o = w_release;
  assign bus.long_o    = w_long;
  assign bus.dbl_o     = w_dbl;
  assign bus.led       = w_led;

endmodule

// File: tb/tb_click_multi.sv
// tb_click_multi: directed, table-driven bench for click_multi with
// N_CH=2, DEB_CNT=4, LONG_CNT=16, DBL_WIN=20.
module tb_click_multi;

  localparam int N_CH     = 2;
  localparam int DEB_CNT  = 4;
  localparam int LONG_CNT = 16;
  localparam int DBL_WIN  = 20;

`ifdef CLICK_MULTI_DBLCLK_EN
  localparam logic EXP_DBL = 1'b1;
  localparam int   EXP_DBL_TOTAL = 1;
`else
  localparam logic EXP_DBL = 1'b0;
  localparam int   EXP_DBL_TOTAL = 0;
`endif

  typedef struct {
    logic [1:0] button;
    int         cycles;
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] lng;
    logic [1:0] led;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  int   pressCnt[N_CH]   = '{default: 0};
  int   releaseCnt[N_CH] = '{default: 0};
  int   longCnt[N_CH]    = '{default: 0};
  int   dblCnt[N_CH]     = '{default: 0};
  int   lastPressCyc[N_CH] = '{default: 0};
  int   lastLongCyc[N_CH]  = '{default: 0};
  logic bounceWatch = 1'b0;
  logic lvl0Seen = 1'b0;
  vec_t vecs[8];

  click_multi_if #(.N_CH(N_CH)) bus ();

  click_multi #(
    .N_CH     (N_CH),
    .DEB_CNT  (DEB_CNT),
    .LONG_CNT (LONG_CNT),
    .DBL_WIN  (DBL_WIN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Pulse scoreboard sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < N_CH; c++) begin
        if (bus.press_o[c])   begin pressCnt[c]++; lastPressCyc[c] = cycle; end
        if (bus.release_o[c]) releaseCnt[c]++;
        if (bus.long_o[c])    begin longCnt[c]++; lastLongCyc[c] = cycle; end
        if (bus.dbl_o[c])     dblCnt[c]++;
      end
      if (bounceWatch && bus.level_o[0]) lvl0Seen = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] b, input int n);
    bus.button = b;
    tick(n);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  initial begin
    int p0, r0, l0, lc;

    vecs[0] = '{2'b11, 5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[1] = '{2'b11, 1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11};
    vecs[2] = '{2'b11, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11};
    vecs[3] = '{2'b00, 5, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11};
    vecs[4] = '{2'b00, 1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11};
    vecs[5] = '{2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11};
    vecs[6] = '{2'b01, 3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11};
    vecs[7] = '{2'b00, 4, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11};

    rst = 1'b1;
    bus.button = 2'b11;
    #12;
    checkOutput("reset.all", {bus.level_o, bus.press_o, bus.release_o,
                              bus.long_o, bus.dbl_o, bus.led}, 0);
    tick(3);
    checkOutput("reset.held", {bus.level_o, bus.press_o, bus.led}, 0);
    rst = 1'b0;

    $display("[TB] table vectors: reset release, press, release, glitch");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].button, vecs[i].cycles);
      checkOutput($sformatf("vec%0d.level", i),   bus.level_o,   vecs[i].level);
      checkOutput($sformatf("vec%0d.press", i),   bus.press_o,   vecs[i].press);
      checkOutput($sformatf("vec%0d.release", i), bus.release_o, vecs[i].rel);
      checkOutput($sformatf("vec%0d.long", i),    bus.long_o,    vecs[i].lng);
      checkOutput($sformatf("vec%0d.led", i),     bus.led,       vecs[i].led);
      checkOutput($sformatf("vec%0d.dbl", i),     bus.dbl_o,     2'b00);
    end

    $display("[TB] bounce rejection on channel 0");
    p0 = pressCnt[0];
    bounceWatch = 1'b1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(2'b01, 3);
      applyStimulus(2'b00, 2);
    end
    tick(3);
    bounceWatch = 1'b0;
    checkOutput("bounce.noLevel", lvl0Seen, 1'b0);
    checkOutput("bounce.noPress", pressCnt[0] - p0, 0);
    applyStimulus(2'b01, 10);
    checkOutput("bounce.onePress", pressCnt[0] - p0, 1);
    checkOutput("bounce.level", bus.level_o[0], 1'b1);
    checkOutput("bounce.ledToggle", bus.led[0], 1'b0);
    applyStimulus(2'b00, 40);

    $display("[TB] long press on channel 1");
    r0 = releaseCnt[1];
    applyStimulus(2'b10, 30);
    checkOutput("long.once", longCnt[1], 1);
    checkOutput("long.offset", lastLongCyc[1] - lastPressCyc[1], LONG_CNT);
    applyStimulus(2'b00, 10);
    checkOutput("long.release", releaseCnt[1] - r0, 1);
    checkOutput("long.noSecond", longCnt[1], 1);
    tick(5);

    $display("[TB] release against long threshold on channel 0");
    r0 = releaseCnt[0];
    applyStimulus(2'b01, 16);
    applyStimulus(2'b00, 10);
    checkOutput("collide.release", releaseCnt[0] - r0, 1);
    checkOutput("collide.noLong", longCnt[0], 0);
    tick(30);
    applyStimulus(2'b01, 17);
    applyStimulus(2'b00, 10);
    checkOutput("collide.lateLong", longCnt[0], 1);
    tick(30);

    $display("[TB] double-click sequences on channel 0");
    applyStimulus(2'b01, 6);
    checkOutput("dbl.press1", bus.press_o[0], 1'b1);
    checkOutput("dbl.first", bus.dbl_o[0], 1'b0);
    applyStimulus(2'b00, 6);
    checkOutput("dbl.release1", bus.release_o[0], 1'b1);
    tick(8);
    applyStimulus(2'b01, 6);
    checkOutput("dbl.press2", bus.press_o[0], 1'b1);
    checkOutput("dbl.second", bus.dbl_o[0], EXP_DBL);
    applyStimulus(2'b00, 6);
    checkOutput("dbl.release2", bus.release_o[0], 1'b1);
    tick(8);
    applyStimulus(2'b01, 6);
    checkOutput("dbl.press3", bus.press_o[0], 1'b1);
    checkOutput("dbl.thirdFresh", bus.dbl_o[0], 1'b0);
    applyStimulus(2'b00, 6);
    checkOutput("dbl.release3", bus.release_o[0], 1'b1);
    tick(25);
    applyStimulus(2'b01, 6);
    checkOutput("dbl.press4", bus.press_o[0], 1'b1);
    checkOutput("dbl.expired", bus.dbl_o[0], 1'b0);
    applyStimulus(2'b00, 10);

    $display("[TB] asynchronous reset during a hold on channel 1");
    applyStimulus(2'b10, 6);
    checkOutput("rstHold.press", bus.press_o[1], 1'b1);
    tick(5);
    rst = 1'b1;
    #2;
    checkOutput("rstHold.clear", {bus.level_o, bus.press_o, bus.release_o,
                                  bus.long_o, bus.dbl_o, bus.led}, 0);
    tick(2);
    rst = 1'b0;
    lc = longCnt[1];
    tick(6);
    checkOutput("rstHold.rePress", bus.press_o[1], 1'b1);
    checkOutput("rstHold.level", bus.level_o[1], 1'b1);
    tick(15);
    checkOutput("rstHold.noEarlyLong", bus.long_o[1], 1'b0);
    checkOutput("rstHold.longCount", longCnt[1] - lc, 0);
    tick(1);
    checkOutput("rstHold.long", bus.long_o[1], 1'b1);
    applyStimulus(2'b00, 10);

    checkOutput("dbl.total0", dblCnt[0], EXP_DBL_TOTAL);
    checkOutput("dbl.total1", dblCnt[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
